// File: rtl/input_spi_rx.sv
// Receive side of the serial byte link: resynchronises sclk/en/sdi into clk,
// deserialises MSB-first words and presents them on a valid/ready handshake.
module input_spi_rx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk_in,
  input  logic              en_in,
  input  logic              sdi,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  input  logic              ready_in,
  output logic              overrun,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] en_sync;
  logic [SYNC_STAGES-1:0] sdi_sync;
  logic                   sclk_prev;

  logic [0:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shreg;

  logic              sclk_s;
  logic              en_s;
  logic              sdi_s;
  logic              sclk_rise;
  logic              word_done;
  logic [DATA_W-1:0] word_next;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign en_s      = en_sync[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign word_next = {shreg[DATA_W-2:0], sdi_s};
  // An en rise in the same cycle as an sclk rise wins: the sample never counts.
  assign word_done = (state == SHIFT) && !en_s && sclk_rise &&
                     (cnt == CNT_W'(DATA_W - 1));
  assign busy      = (state == SHIFT);

  // All three lines share one synchroniser depth so they stay mutually aligned.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sclk_sync <= '1;
      en_sync   <= '1;
      sdi_sync  <= '0;
      sclk_prev <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
      en_sync   <= {en_sync[SYNC_STAGES-2:0], en_in};
      sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi};
      sclk_prev <= sclk_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      // NOTE: pulses default low here; a later non-blocking write in this block overrides it.
      overrun   <= 1'b0;
      frame_err <= 1'b0;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (!en_s) state <= SHIFT;
        end
        SHIFT: begin
          if (en_s) begin
            state     <= IDLE;
            cnt       <= '0;
            shreg     <= '0;
            frame_err <= (cnt != '0);
          end else if (sclk_rise) begin
            shreg <= word_next;
            cnt   <= word_done ? '0 : cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase

      // Holding register: a full, unaccepted word is never overwritten.
      if (word_done) begin
        if (!valid_out || ready_in) begin
          data_out  <= word_next;
          valid_out <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid_out && ready_in) begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_input_spi_rx.sv
// Self-checking bench for input_spi_rx: expected words queued at send time,
// compared by a monitor at each accepted handshake.
module tb_input_spi_rx;

  localparam int DATA_W      = 8;
  localparam int SYNC_STAGES = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              sclk_in = 1'b0;
  logic              en_in = 1'b1;
  logic              sdi = 1'b0;
  logic              ready_in = 1'b0;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              overrun;
  logic              frame_err;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;
  int acc_cnt  = 0;
  int ovr_cnt  = 0;
  int ferr_cnt = 0;

  logic [DATA_W-1:0] exp_q[$];

  input_spi_rx #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .sclk_in   (sclk_in),
    .en_in     (en_in),
    .sdi       (sdi),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .overrun   (overrun),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Scoreboard side: every accepted handshake must match the oldest queued word.
  always @(negedge clk) begin
    if (rst) begin
      if (overrun)   ovr_cnt++;
      if (frame_err) ferr_cnt++;
      if (valid_out && ready_in) begin
        logic [DATA_W-1:0] exp_w;
        acc_cnt++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL accept_unexpected: data_out=%h, no word queued", data_out);
        end else begin
          exp_w = exp_q.pop_front();
          if (data_out !== exp_w) begin
            n_fail++;
            $display("FAIL accept_data: data_out=%h expected=%h", data_out, exp_w);
          end
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    sclk_in = 1'b0;
    sdi     = b;
    wait_clk(3);
    sclk_in = 1'b1;
    wait_clk(3);
  endtask

  task automatic send_byte(input logic [DATA_W-1:0] w);
    for (int i = DATA_W - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic test_reset;
    rst      = 1'b0;
    ready_in = 1'b0;
    en_in    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sclk_in = ~sclk_in;
      sdi     = ~sdi;
      wait_clk(1);
    end
    n_checks++;
    if (data_out !== '0) begin n_fail++; $display("FAIL reset_data: got=%h expected=00", data_out); end
    n_checks++;
    if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got=%b expected=0", valid_out); end
    n_checks++;
    if (overrun !== 1'b0 || frame_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_pulses: overrun=%b frame_err=%b expected=0/0", overrun, frame_err);
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got=%b expected=0", busy); end
    en_in   = 1'b1;
    sclk_in = 1'b0;
    sdi     = 1'b0;
    rst     = 1'b1;
    wait_clk(4);
    n_checks++;
    if (busy !== 1'b0 || valid_out !== 1'b0) begin
      n_fail++; $display("FAIL post_reset: busy=%b valid=%b expected=0/0", busy, valid_out);
    end
  endtask

  task automatic test_reset_midframe;
    int ferr0 = ferr_cnt;
    en_in = 1'b0;
    wait_clk(4);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    rst = 1'b0;
    wait_clk(2);
    rst     = 1'b1;
    en_in   = 1'b1;
    sclk_in = 1'b0;
    wait_clk(6);
    n_checks++;
    if (ferr_cnt !== ferr0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_midframe: frame_err pulses=%0d busy=%b expected=0/0", ferr_cnt - ferr0, busy);
    end
  endtask

  task automatic test_single_byte;
    int ferr0 = ferr_cnt;
    int acc0  = acc_cnt;
    logic [DATA_W-1:0] w = 8'h01;
    ready_in = 1'b1;
    en_in    = 1'b0;
    wait_clk(4);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got=%b expected=1", busy); end
    exp_q.push_back(w);
    for (int i = DATA_W - 1; i >= 1; i--) send_bit(w[i]);
    sclk_in = 1'b0;
    sdi     = w[0];
    wait_clk(3);
    sclk_in = 1'b1;
    for (int i = 0; i < SYNC_STAGES; i++) begin
      wait_clk(1);
      n_checks++;
      if (valid_out !== 1'b0) begin
        n_fail++; $display("FAIL single_early: valid=%b expected=0 at clk %0d after edge", valid_out, i + 1);
      end
    end
    wait_clk(1);
    n_checks++;
    if (valid_out !== 1'b1 || data_out !== 8'h01) begin
      n_fail++; $display("FAIL single_latency: valid=%b data=%h expected=1/01", valid_out, data_out);
    end
    wait_clk(2);
    en_in = 1'b1;
    wait_clk(5);
    n_checks++;
    if (ferr_cnt !== ferr0 || acc_cnt !== acc0 + 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL single_end: frame_err=%0d accepted=%0d busy=%b expected=0/1/0",
                         ferr_cnt - ferr0, acc_cnt - acc0, busy);
    end
  endtask

  task automatic test_back_to_back;
    int acc0 = acc_cnt;
    int ovr0 = ovr_cnt;
    ready_in = 1'b1;
    en_in    = 1'b0;
    wait_clk(4);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    send_byte(8'h01);
    send_byte(8'h02);
    wait_clk(3);
    en_in = 1'b1;
    wait_clk(6);
    n_checks++;
    if (acc_cnt !== acc0 + 2 || ovr_cnt !== ovr0) begin
      n_fail++; $display("FAIL back_to_back: accepted=%0d overruns=%0d expected=2/0", acc_cnt - acc0, ovr_cnt - ovr0);
    end
  endtask

  task automatic test_overrun;
    int acc0 = acc_cnt;
    int ovr0 = ovr_cnt;
    ready_in = 1'b0;
    en_in    = 1'b0;
    wait_clk(4);
    exp_q.push_back(8'hA5);
    send_byte(8'hA5);
    send_byte(8'h3C);
    wait_clk(6);
    en_in = 1'b1;
    wait_clk(4);
    n_checks++;
    if (data_out !== 8'hA5 || valid_out !== 1'b1) begin
      n_fail++; $display("FAIL overrun_hold: data=%h valid=%b expected=a5/1", data_out, valid_out);
    end
    n_checks++;
    if (ovr_cnt !== ovr0 + 1) begin
      n_fail++; $display("FAIL overrun_pulse: pulse cycles=%0d expected=1", ovr_cnt - ovr0);
    end
    ready_in = 1'b1;
    wait_clk(1);
    n_checks++;
    if (valid_out !== 1'b0 || data_out !== 8'hA5 || acc_cnt !== acc0 + 1) begin
      n_fail++; $display("FAIL overrun_drain: valid=%b data=%h accepted=%0d expected=0/a5/1",
                         valid_out, data_out, acc_cnt - acc0);
    end
  endtask

  task automatic test_abort;
    int acc0  = acc_cnt;
    int ferr0 = ferr_cnt;
    ready_in = 1'b1;
    en_in    = 1'b0;
    wait_clk(4);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    en_in = 1'b1;
    wait_clk(6);
    n_checks++;
    if (ferr_cnt !== ferr0 + 1 || valid_out !== 1'b0 || acc_cnt !== acc0) begin
      n_fail++; $display("FAIL abort: frame_err cycles=%0d valid=%b accepted=%0d expected=1/0/0",
                         ferr_cnt - ferr0, valid_out, acc_cnt - acc0);
    end
    en_in = 1'b0;
    wait_clk(4);
    exp_q.push_back(8'h80);
    send_byte(8'h80);
    en_in = 1'b1;
    wait_clk(6);
    n_checks++;
    if (acc_cnt !== acc0 + 1 || ferr_cnt !== ferr0 + 1) begin
      n_fail++; $display("FAIL abort_recover: accepted=%0d frame_err cycles=%0d expected=1/1",
                         acc_cnt - acc0, ferr_cnt - ferr0);
    end
  endtask

  task automatic test_accept_complete;
    int acc0 = acc_cnt;
    int ovr0 = ovr_cnt;
    logic [DATA_W-1:0] w = 8'h22;
    ready_in = 1'b0;
    en_in    = 1'b0;
    wait_clk(4);
    exp_q.push_back(8'h11);
    send_byte(8'h11);
    exp_q.push_back(w);
    for (int i = DATA_W - 1; i >= 1; i--) send_bit(w[i]);
    sclk_in = 1'b0;
    sdi     = w[0];
    wait_clk(3);
    sclk_in = 1'b1;
    wait_clk(SYNC_STAGES);
    ready_in = 1'b1;
    wait_clk(1);
    ready_in = 1'b0;
    n_checks++;
    if (data_out !== 8'h22 || valid_out !== 1'b1 || ovr_cnt !== ovr0) begin
      n_fail++; $display("FAIL accept_complete: data=%h valid=%b overruns=%0d expected=22/1/0",
                         data_out, valid_out, ovr_cnt - ovr0);
    end
    n_checks++;
    if (acc_cnt !== acc0 + 1) begin
      n_fail++; $display("FAIL accept_complete_count: accepted=%0d expected=1", acc_cnt - acc0);
    end
    wait_clk(3);
    en_in    = 1'b1;
    ready_in = 1'b1;
    wait_clk(3);
    n_checks++;
    if (valid_out !== 1'b0 || acc_cnt !== acc0 + 2) begin
      n_fail++; $display("FAIL accept_complete_drain: valid=%b accepted=%0d expected=0/2", valid_out, acc_cnt - acc0);
    end
  endtask

  initial begin
    test_reset();
    test_reset_midframe();
    test_single_byte();
    test_back_to_back();
    test_overrun();
    test_abort();
    test_accept_complete();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL words_missing: %0d queued words never delivered, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
